ram_bank_master: RTL and testbench

RAM_BANK_MASTER -- requirements
Module: ram_bank_master

---
 rtl/ram_bank_master_if.sv | 34 +++
 rtl/ram_bank_master.sv | 175 +++++++++++++++++
 tb/tb_ram_bank_master.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/ram_bank_master_if.sv
// Host request/response and banked-RAM strobe bundle for ram_bank_master.
// master = the bank master block, slave = host plus RAM side.
interface ram_bank_master_if;
    logic       req_valid;
    logic       req_ready;
    logic       req_we;
    logic [4:0] req_addr;
    logic [3:0] req_wdata;
    logic       rsp_valid;
    logic [3:0] rsp_data;
    logic       ram_cs;
    logic       ram_we;
    logic       ram_oe;
    logic [1:0] ram_bank;
    logic [1:0] ram_row;
    logic [1:0] ram_col;
    logic [3:0] ram_din;
    logic [3:0] ram_dout;
    logic       init_busy;

    modport master (
        input  req_valid, req_we, req_addr, req_wdata, ram_dout,
        output req_ready, rsp_valid, rsp_data,
        output ram_cs, ram_we, ram_oe, ram_bank, ram_row, ram_col,
        output ram_din, init_busy
    );

    modport slave (
        output req_valid, req_we, req_addr, req_wdata, ram_dout,
        input  req_ready, rsp_valid, rsp_data,
        input  ram_cs, ram_we, ram_oe, ram_bank, ram_row, ram_col,
        input  ram_din, init_busy
    );
endinterface

// File: rtl/ram_bank_master.sv
// Single-access master for a two-bank 4x4x4 RAM with registered outputs.
// Optional RAM_INIT_EN: zero-fill sweep of all 32 locations after reset.
module ram_bank_master #(
    parameter int unsigned RD_LAT = 1
) (
    input  logic               clk,
    input  logic               rst,
    ram_bank_master_if.master  bus
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        WAIT  = 3'd2,
        RSP   = 3'd3,
        INIT  = 3'd4
    } state_t;

`ifdef RAM_INIT_EN
    localparam state_t RST_STATE = INIT;
`else
    localparam state_t RST_STATE = IDLE;
`endif

    state_t     state;
    state_t     nstate;
    logic       we_q;
    logic [2:0] wcnt;
    logic       hs;

    logic       ready_q;
    logic       rsp_valid_q;
    logic [3:0] rsp_data_q;
    logic       ram_cs_q;
    logic       ram_we_q;
    logic       ram_oe_q;
    logic [1:0] ram_bank_q;
    logic [1:0] ram_row_q;
    logic [1:0] ram_col_q;
    logic [3:0] ram_din_q;

    logic       ram_cs_d;
    logic       ram_we_d;
    logic       ram_oe_d;
    logic [1:0] ram_bank_d;
    logic [1:0] ram_row_d;
    logic [1:0] ram_col_d;
    logic [3:0] ram_din_d;

`ifdef RAM_INIT_EN
    logic [5:0] icnt;
    logic       busy_q;
    logic       init_done;

    assign init_done = (icnt == 6'd32);
`endif

    assign hs = bus.req_valid && ready_q;

    // State and output registers; outputs are computed from the next state
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= RST_STATE;
            we_q        <= 1'b0;
            wcnt        <= 3'd0;
            ready_q     <= (RST_STATE == IDLE);
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= 4'd0;
            ram_cs_q    <= 1'b0;
            ram_we_q    <= 1'b0;
            ram_oe_q    <= 1'b0;
            ram_bank_q  <= 2'd0;
            ram_row_q   <= 2'd0;
            ram_col_q   <= 2'd0;
            ram_din_q   <= 4'd0;
`ifdef RAM_INIT_EN
            icnt        <= 6'd0;
            busy_q      <= 1'b1;
`endif
        end else begin
            state       <= nstate;
            ready_q     <= (nstate == IDLE);
            rsp_valid_q <= (nstate == RSP);
            ram_cs_q    <= ram_cs_d;
            ram_we_q    <= ram_we_d;
            ram_oe_q    <= ram_oe_d;
            ram_bank_q  <= ram_bank_d;
            ram_row_q   <= ram_row_d;
            ram_col_q   <= ram_col_d;
            ram_din_q   <= ram_din_d;
            if (hs) begin
                we_q <= bus.req_we;
            end
            if (state == ISSUE) begin
                wcnt <= 3'(RD_LAT - 1);
            end else if (state == WAIT && wcnt != 3'd0) begin
                wcnt <= wcnt - 3'd1;
            end
            // RAM dout is valid from the first WAIT cycle onward
            if (state == WAIT && wcnt == 3'd0) begin
                rsp_data_q <= bus.ram_dout;
            end
`ifdef RAM_INIT_EN
            busy_q <= (nstate == INIT);
            if (state == INIT && !init_done) begin
                icnt <= icnt + 6'd1;
            end
`endif
        end
    end

    always_comb begin
        nstate = state;
        unique case (state)
            IDLE:    if (hs) nstate = ISSUE;
            ISSUE:   nstate = we_q ? IDLE : WAIT;
            WAIT:    if (wcnt == 3'd0) nstate = RSP;
            RSP:     nstate = IDLE;
`ifdef RAM_INIT_EN
            INIT:    if (init_done) nstate = IDLE;
`else
            INIT:    nstate = IDLE;
`endif
            default: nstate = IDLE;
        endcase
    end

    // ISSUE is entered only through a handshake, so the request fields
    // are the captured fields for the coming ISSUE cycle.
    always_comb begin
        ram_cs_d   = 1'b0;
        ram_we_d   = 1'b0;
        ram_oe_d   = 1'b0;
        ram_bank_d = 2'd0;
        ram_row_d  = 2'd0;
        ram_col_d  = 2'd0;
        ram_din_d  = 4'd0;
        if (nstate == ISSUE) begin
            ram_cs_d   = 1'b1;
            ram_we_d   = bus.req_we;
            ram_oe_d   = ~bus.req_we;
            ram_bank_d = {1'b0, bus.req_addr[4]};
            ram_row_d  = bus.req_addr[3:2];
            ram_col_d  = bus.req_addr[1:0];
            ram_din_d  = bus.req_wdata;
        end
`ifdef RAM_INIT_EN
        else if (nstate == INIT && !init_done) begin
            ram_cs_d   = 1'b1;
            ram_we_d   = 1'b1;
            ram_bank_d = {1'b0, icnt[4]};
            ram_row_d  = icnt[3:2];
            ram_col_d  = icnt[1:0];
        end
`endif
    end

    assign bus.req_ready = ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.ram_cs    = ram_cs_q;
    assign bus.ram_we    = ram_we_q;
    assign bus.ram_oe    = ram_oe_q;
    assign bus.ram_bank  = ram_bank_q;
    assign bus.ram_row   = ram_row_q;
    assign bus.ram_col   = ram_col_q;
    assign bus.ram_din   = ram_din_q;

`ifdef RAM_INIT_EN
    assign bus.init_busy = busy_q;
`else
    assign bus.init_busy = 1'b0;
`endif

endmodule

// File: tb/tb_ram_bank_master.sv
// Bench for ram_bank_master: RAM models, reference memory, directed
// scenarios plus randomized traffic on an RD_LAT=1 and an RD_LAT=3 instance.
module tb_ram_bank_master;

    localparam int LAT_A = 1;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   passed = 0;
    int   total = 0;

    logic [3:0] mem_ref [32];
    logic [3:0] last_rd;
    logic [3:0] ram_a [32];
    logic [3:0] ram_b [32];

    ram_bank_master_if a ();
    ram_bank_master_if b ();

    ram_bank_master #(.RD_LAT(LAT_A)) dut_a (.clk(clk), .rst(rst), .bus(a));
    ram_bank_master #(.RD_LAT(3))     dut_b (.clk(clk), .rst(rst), .bus(b));

    always #5 clk = ~clk;

    // Synchronous RAMs: writes and read-data registration on the issue edge
    always @(posedge clk) begin
        if (a.ram_cs) begin
            if (a.ram_we) ram_a[{a.ram_bank[0], a.ram_row, a.ram_col}] <= a.ram_din;
            if (a.ram_oe) a.ram_dout <= ram_a[{a.ram_bank[0], a.ram_row, a.ram_col}];
        end
    end

    always @(posedge clk) begin
        if (b.ram_cs) begin
            if (b.ram_we) ram_b[{b.ram_bank[0], b.ram_row, b.ram_col}] <= b.ram_din;
            if (b.ram_oe) b.ram_dout <= ram_b[{b.ram_bank[0], b.ram_row, b.ram_col}];
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic logic [15:0] bus_a();
        return 16'({a.ram_cs, a.ram_we, a.ram_oe, a.ram_bank,
                    a.ram_row, a.ram_col, a.ram_din});
    endfunction

    function automatic logic [15:0] bus_b();
        return 16'({b.ram_cs, b.ram_we, b.ram_oe, b.ram_bank,
                    b.ram_row, b.ram_col, b.ram_din});
    endfunction

    task automatic wait_ready_a();
        int n = 0;
        while (a.req_ready !== 1'b1 && n < 64) begin
            tick();
            n++;
        end
        chk("a_ready_wait", 16'(a.req_ready), 16'd1);
    endtask

    // One accepted access on instance a, checked cycle by cycle
    task automatic txn(input logic we, input logic [4:0] ad,
                       input logic [3:0] d, input logic hold);
        logic [3:0] exp;
        wait_ready_a();
        a.req_valid = 1'b1;
        a.req_we    = we;
        a.req_addr  = ad;
        a.req_wdata = d;
        tick();
        if (hold) begin
            a.req_we    = 1'($urandom);
            a.req_addr  = 5'($urandom);
            a.req_wdata = 4'($urandom);
        end else begin
            a.req_valid = 1'b0;
        end
        if (we) mem_ref[ad] = d;
        exp = mem_ref[ad];
        chk("issue_bus", bus_a(), 16'({1'b1, we, ~we, 1'b0, ad, d}));
        chk("issue_ready", 16'(a.req_ready), 16'd0);
        chk("issue_rsp", 16'(a.rsp_valid), 16'd0);
        if (we) begin
            a.req_valid = 1'b0;
            tick();
            chk("wr_idle_ready", 16'(a.req_ready), 16'd1);
            chk("wr_idle_bus", bus_a(), 16'd0);
            chk("rsp_hold_wr", 16'(a.rsp_data), 16'(last_rd));
        end else begin
            for (int i = 0; i < LAT_A; i++) begin
                tick();
                chk("wait_bus", bus_a(), 16'd0);
                chk("wait_rsp", 16'(a.rsp_valid), 16'd0);
                chk("wait_ready", 16'(a.req_ready), 16'd0);
            end
            a.req_valid = 1'b0;
            tick();
            chk("rsp_valid", 16'(a.rsp_valid), 16'd1);
            chk("rsp_data", 16'(a.rsp_data), 16'(exp));
            chk("rsp_bus", bus_a(), 16'd0);
            tick();
            chk("post_rsp_valid", 16'(a.rsp_valid), 16'd0);
            chk("post_rsp_ready", 16'(a.req_ready), 16'd1);
            chk("rsp_hold", 16'(a.rsp_data), 16'(exp));
            last_rd = exp;
        end
    endtask

    task automatic reset_checks(input string tag);
`ifdef RAM_INIT_EN
        chk({tag, "_ready"}, 16'(a.req_ready), 16'd0);
        chk({tag, "_busy"}, 16'(a.init_busy), 16'd1);
`else
        chk({tag, "_ready"}, 16'(a.req_ready), 16'd1);
        chk({tag, "_busy"}, 16'(a.init_busy), 16'd0);
`endif
        chk({tag, "_rsp_valid"}, 16'(a.rsp_valid), 16'd0);
        chk({tag, "_rsp_data"}, 16'(a.rsp_data), 16'd0);
        chk({tag, "_bus"}, bus_a(), 16'd0);
        last_rd = 4'd0;
`ifdef RAM_INIT_EN
        for (int k = 0; k < 32; k++) mem_ref[k] = 4'd0;
`endif
    endtask

    initial begin
        logic [4:0] ad;
        a.req_valid = 1'b0; a.req_we = 1'b0; a.req_addr = '0; a.req_wdata = '0;
        b.req_valid = 1'b0; b.req_we = 1'b0; b.req_addr = '0; b.req_wdata = '0;
        last_rd = 4'd0;
        for (int k = 0; k < 32; k++) mem_ref[k] = 4'd0;

        rst = 1'b1;
        tick();
        tick();
        reset_checks("reset");
        rst = 1'b0;
`ifdef RAM_INIT_EN
        for (int k = 0; k < 32; k++) begin
            tick();
            chk("init_bus", bus_a(), 16'({3'b110, 1'b0, 5'(k), 4'd0}));
            chk("init_busy", 16'(a.init_busy), 16'd1);
            chk("init_ready", 16'(a.req_ready), 16'd0);
        end
        tick();
        chk("init_end_busy", 16'(a.init_busy), 16'd0);
        chk("init_end_ready", 16'(a.req_ready), 16'd1);
        chk("init_end_bus", bus_a(), 16'd0);
        txn(1'b0, 5'd31, 4'd0, 1'b0);
`endif

        // Write then read the same location two cycles later
        txn(1'b1, 5'b10110, 4'hA, 1'b0);
        txn(1'b0, 5'b10110, 4'h0, 1'b0);

        // Bank isolation between addr 0 and addr 16
        txn(1'b1, 5'd0, 4'h3, 1'b0);
        txn(1'b1, 5'd16, 4'hC, 1'b0);
        txn(1'b0, 5'd0, 4'h0, 1'b0);
        txn(1'b0, 5'd16, 4'h0, 1'b0);

        // Fill every location so later random reads hit known data
        for (int k = 0; k < 32; k++) txn(1'b1, 5'(k), 4'($urandom), 1'b0);

        // RD_LAT=3 instance: response exactly 5 cycles after accept
        begin
            int n = 0;
            while (b.req_ready !== 1'b1 && n < 64) begin
                tick();
                n++;
            end
            chk("b_ready_wait", 16'(b.req_ready), 16'd1);
            b.req_valid = 1'b1; b.req_we = 1'b1; b.req_addr = 5'd9; b.req_wdata = 4'h7;
            tick();
            b.req_valid = 1'b0;
            chk("b_issue_bus", bus_b(), 16'({3'b110, 1'b0, 5'd9, 4'h7}));
            tick();
            chk("b_wr_ready", 16'(b.req_ready), 16'd1);
            b.req_valid = 1'b1; b.req_we = 1'b0;
            tick();
            b.req_valid = 1'b0;
            for (int c = 1; c <= 7; c++) begin
                chk("b_lat3_rsp_valid", 16'(b.rsp_valid), 16'(c == 5));
                if (c == 5) chk("b_lat3_rsp_data", 16'(b.rsp_data), 16'h7);
                if (c < 7) tick();
            end
        end

        // Randomized traffic, half with req_valid held while busy
        for (int i = 0; i < 40; i++) begin
            txn(1'($urandom), 5'($urandom), 4'($urandom), 1'($urandom));
        end

        // Reset during WAIT aborts the read
        ad = 5'd3;
        txn(1'b1, ad, 4'hF, 1'b0);
        txn(1'b0, ad, 4'h0, 1'b0);
        wait_ready_a();
        a.req_valid = 1'b1; a.req_we = 1'b0; a.req_addr = ad;
        tick();
        a.req_valid = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        reset_checks("midrd");
        tick();
        chk("midrd_no_rsp", 16'(a.rsp_valid), 16'd0);
        for (int c = 0; c < 40; c++) begin
            tick();
            chk("midrd_late_rsp", 16'(a.rsp_valid), 16'd0);
        end
        txn(1'b0, ad, 4'h0, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
